// File: rtl/sdp_rd_port.sv
// -----------------------------------------------------------------------------
// sdp_rd_port
//
// Read port for a simple dual-port RAM with one clock of read latency.
// Accepts read addresses on a valid/ready stream, issues them to the memory,
// captures the returned word one clock later into a 2-entry in-order skid
// FIFO, and presents it on a valid/ready read-data stream. Flow control
// guarantees that every word already requested from the memory has a free FIFO
// slot waiting for it, so no returned word can ever be dropped.
//
// Build option:
//   SDP_RD_PORT_FAST_READY_EN
//     undefined : addr_if_ready comes from registers only
//                 (sustained 2 words per 3 clocks).
//     defined   : addr_if_ready also counts a pop in the same cycle, which
//                 makes it combinational on data_if_ready
//                 (sustained 1 word per clock).
//
// Ports (stream bundles flattened as <bundle>_valid/_ready/_data):
//   clk            in   1       clock, all state on the rising edge
//   rst            in   1       asynchronous reset, active low
//   addr_if_valid  in   1       read-address stream valid     (consumer side)
//   addr_if_ready  out  1       read-address stream ready
//   addr_if_data   in   W_ADDR  read address
//   data_if_valid  out  1       read-data stream valid        (producer side)
//   data_if_ready  in   1       read-data stream ready
//   data_if_data   out  W_DATA  read data, FIFO head
//   en_o           out  1       memory read enable
//   addr_o         out  W_ADDR  memory read address
//   data_i         in   W_DATA  memory read data, valid one clock after en_o
// -----------------------------------------------------------------------------
module sdp_rd_port #(
   parameter int unsigned W_DATA = 16,
   parameter int unsigned W_ADDR = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              addr_if_valid,
   output logic              addr_if_ready,
   input  logic [W_ADDR-1:0] addr_if_data,
   output logic              data_if_valid,
   input  logic              data_if_ready,
   output logic [W_DATA-1:0] data_if_data,
   output logic              en_o,
   output logic [W_ADDR-1:0] addr_o,
   input  logic [W_DATA-1:0] data_i
);

   logic              pend;        // a read was issued last clock; data_i is live now
   logic [1:0]        cnt;         // FIFO occupancy, 0..2
   logic              wr_ptr;
   logic              rd_ptr;
   logic [W_DATA-1:0] fifo_mem [2];

   logic              push;
   logic              pop;
   logic [2:0]        occ;         // words in flight plus words stored

   assign push = pend;
   assign pop  = data_if_valid & data_if_ready;
   assign occ  = 3'(cnt) + 3'(pend);

   // Ready is gated with rst so that nothing is accepted while reset is held,
   // independent of the register values.
`ifdef SDP_RD_PORT_FAST_READY_EN
   // A pop this clock frees a slot in time for a word issued this clock
   // (it lands two clocks later), so it may be counted as free already.
   assign addr_if_ready = rst & ((occ - 3'(pop)) < 3'd2);
`else
   assign addr_if_ready = rst & (occ < 3'd2);
`endif

   assign en_o   = addr_if_valid & addr_if_ready;
   assign addr_o = addr_if_data;

   assign data_if_valid = (cnt != 2'd0);
   assign data_if_data  = fifo_mem[rd_ptr];

   // Pending-read flag: the memory returns data exactly one clock after en_o.
   // Being cleared by reset also makes the first post-reset data_i be ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= 1'b0;
      end else begin
         pend <= en_o;
      end
   end

   // FIFO control. Occupancy accounting above guarantees push never hits a
   // full FIFO, so no overflow guard is needed here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= data_i;
      end
   end

endmodule

// File: tb/tb_sdp_rd_port.sv
module tb_sdp_rd_port;

   localparam int unsigned W_DATA = 16;
   localparam int unsigned W_ADDR = 16;

`ifdef SDP_RD_PORT_FAST_READY_EN
   localparam int B2B_CLKS = 8;
`else
   localparam int B2B_CLKS = 10;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              av;
   logic              ar;
   logic [W_ADDR-1:0] a;
   logic              dv;
   logic              dr;
   logic [W_DATA-1:0] dd;
   logic              en_o;
   logic [W_ADDR-1:0] addr_o;
   logic [W_DATA-1:0] data_i;

   always #5 clk = ~clk;

   sdp_rd_port #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
      .clk           (clk),
      .rst           (rst),
      .addr_if_valid (av),
      .addr_if_ready (ar),
      .addr_if_data  (a),
      .data_if_valid (dv),
      .data_if_ready (dr),
      .data_if_data  (dd),
      .en_o          (en_o),
      .addr_o        (addr_o),
      .data_i        (data_i)
   );

   // Memory model: one clock read latency, junk when not enabled.
   logic [15:0] mem [256];
   always @(posedge clk) data_i <= en_o ? mem[addr_o[7:0]] : 16'hDEAD;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic spurious(input string name, input logic [31:0] act);
      n_checks++;
      $display("FAIL %s: got %0h expected no word", name, act);
   endtask

   // Protocol monitor: held data must stay stable, and in-flight plus stored
   // words never exceed the two FIFO slots.
   bit          mon_on = 1'b0;
   logic        hold_v = 1'b0;
   logic [15:0] hold_d;
   always @(negedge clk) begin
      #2;
      if (mon_on) begin
         if (hold_v) check("stable", 32'({dv, dd}), 32'({1'b1, hold_d}));
         check("inv", 32'((int'(dut.pend) + int'(dut.cnt)) <= 2), 32'd1);
      end
      hold_v = mon_on & dv & ~dr;
      hold_d = dd;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        av;
      logic [15:0] a;
      logic        dr;
      logic        en;
      logic        chk_ar;
      logic        ar;
      logic        dv;
      logic [15:0] dd;
   } vec_t;

   vec_t        tbl [18];
   logic [15:0] exp_q [$];
   logic [15:0] ev;
   int          issued, popped, cyc, first_hs, first_v, last_pop;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'hC3, 8'(i)};
      mem[5] = 16'hBEEF;

      //            av  a       dr   en  chk ar  dv  dd
      tbl[0]  = '{1'b1, 16'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[2]  = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF};
      tbl[3]  = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF};
      tbl[4]  = '{1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[5]  = '{1'b1, 16'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[6]  = '{1'b1, 16'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
      for (int i = 7; i <= 14; i++)
         tbl[i] = '{1'b1, 16'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hD310};
      tbl[15] = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hD310};
      tbl[16] = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hD211};
      tbl[17] = '{1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};

      // Reset state, with a valid address offered.
      rst = 1'b0; av = 1'b1; a = 16'h0005; dr = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_dv", 32'(dv), 32'd0);
      check("rst_ar", 32'(ar), 32'd0);
      check("rst_en", 32'(en_o), 32'd0);
      check("rst_state", 32'({dut.pend, dut.cnt, dut.wr_ptr, dut.rd_ptr}), 32'd0);
      av = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Directed table: single read, then 10 clocks of backpressure and drain.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         av = tbl[i].av; a = tbl[i].a; dr = tbl[i].dr;
         #1;
         check($sformatf("t%0d_en", i), 32'(en_o), 32'(tbl[i].en));
         if (tbl[i].en) check($sformatf("t%0d_addr", i), 32'(addr_o), 32'(tbl[i].a));
         if (tbl[i].chk_ar) check($sformatf("t%0d_ar", i), 32'(ar), 32'(tbl[i].ar));
         check($sformatf("t%0d_dv", i), 32'(dv), 32'(tbl[i].dv));
         if (tbl[i].dv) check($sformatf("t%0d_dd", i), 32'(dd), 32'(tbl[i].dd));
      end

      // Back-to-back, consumer always ready: order, latency, total clocks.
      issued = 0; popped = 0; cyc = 0; first_hs = -1; first_v = -1; last_pop = -1;
      exp_q.delete();
      dr = 1'b1;
      while (popped < 6 && cyc < 60) begin
         @(negedge clk);
         av = (issued < 6);
         a  = 16'(issued);
         #1;
         if (dv && first_v < 0) first_v = cyc;
         if (dv && dr) begin
            if (exp_q.size() == 0) spurious("b2b_data", 32'(dd));
            else begin
               ev = exp_q.pop_front();
               check($sformatf("b2b_data%0d", popped), 32'(dd), 32'(ev));
            end
            popped++;
            last_pop = cyc;
         end
         if (av && ar) begin
            exp_q.push_back(mem[a[7:0]]);
            if (first_hs < 0) first_hs = cyc;
            issued++;
         end
         cyc++;
      end
      av = 1'b0;
      check("b2b_count", 32'(popped), 32'd6);
      check("b2b_latency", 32'(first_v - first_hs), 32'd2);
      check("b2b_clks", 32'(last_pop - first_hs + 1), 32'(B2B_CLKS));

      // Reset between edges with pend=1, cnt=1.
      @(negedge clk);
      av = 1'b1; a = 16'h0020; dr = 1'b0;
      @(negedge clk);
      a = 16'h0021;
      @(negedge clk);
      av = 1'b0;
      #1;
      check("mid_pend_cnt", 32'({dut.pend, dut.cnt}), 32'({1'b1, 2'd1}));
      check("mid_dv", 32'(dv), 32'd1);
      #2;
      rst = 1'b0;
      av = 1'b1; a = 16'h0022; dr = 1'b1;
      #1;
      check("arst_dv", 32'(dv), 32'd0);
      check("arst_ar", 32'(ar), 32'd0);
      check("arst_en", 32'(en_o), 32'd0);
      repeat (2) @(negedge clk);
      a = 16'h0040;
      #2;
      rst = 1'b1;
      #1;
      check("rel_en", 32'(en_o), 32'd1);
      first_v = -1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         av = 1'b0;
         #1;
         if (dv && first_v < 0) begin
            first_v = k;
            check("rel_first_word", 32'(dd), 32'(mem[8'h40]));
         end
      end
      check("rel_latency", 32'(first_v), 32'd2);
      check("rel_drained", 32'(dv), 32'd0);

      // Random valid/ready against the memory model with a scoreboard.
      issued = 0; popped = 0; cyc = 0;
      exp_q.delete();
      mon_on = 1'b1;
      while (popped < 1000 && cyc < 20000) begin
         @(negedge clk);
         av = (issued < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         a  = 16'($urandom);
         dr = 1'($urandom_range(0, 1));
         #1;
         if (dv && dr) begin
            if (exp_q.size() == 0) spurious("rnd_data", 32'(dd));
            else begin
               ev = exp_q.pop_front();
               check("rnd_data", 32'(dd), 32'(ev));
            end
            popped++;
         end
         if (av && ar) begin
            exp_q.push_back(mem[a[7:0]]);
            issued++;
         end
         cyc++;
      end
      @(negedge clk);
      av = 1'b0; dr = 1'b0;
      mon_on = 1'b0;
      check("rnd_count", 32'(popped), 32'd1000);
      check("rnd_left", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
